// File: rtl/ctl_pkg.sv
// ctl_pkg: shared definitions for the program loader / run controller.
//   state_t          : sequencer states (IDLE, LOAD, RUN, HALT)
//   DEFAULT_HALT_ADR : address whose store by the core ends a run
package ctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [7:0] DEFAULT_HALT_ADR = 8'hFF;

endpackage

// File: rtl/port_mux.sv
// port_mux: steers either the program loader or the core onto the single
// memory port, selected by the sequencer state.
//   state            : current (reset-qualified) sequencer state
//   load_valid/adr/data : loader write request
//   core_*           : core memory bus
//   mem_*            : memory port (all zero when neither side owns it)
module port_mux
  import ctl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  state_t             state,
  input  logic               load_valid,
  input  logic [WIDTH-1:0]   load_adr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               core_memread,
  input  logic               core_memwrite,
  input  logic [WIDTH-1:0]   core_adr,
  input  logic [WIDTH-1:0]   core_writedata,
  output logic               mem_re,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_adr,
  output logic [WIDTH-1:0]   mem_wdata
);

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state)
      LOAD: begin
        // load_ready is always high in LOAD, so every valid byte is written
        mem_we    = load_valid;
        mem_adr   = load_adr;
        mem_wdata = load_data;
      end
      RUN: begin
        mem_re    = core_memread;
        mem_we    = core_memwrite;
        mem_adr   = core_adr;
        mem_wdata = core_writedata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/prog_loader_ctl.sv
// prog_loader_ctl: owns the shared byte-wide memory port. Holds the core in
// reset while a byte stream is written to ascending addresses, then releases
// the core and passes its memory traffic through until it stores to HALT_ADR
// or the run-cycle budget expires.
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a load (accepted in IDLE or HALT only)
//   load_valid/data/last, load_ready : program byte stream handshake
//   core_memread/memwrite/adr/writedata : core bus
//   core_reset        : reset to the core (low only in RUN)
//   mem_re/we/adr/wdata : memory port
//   done, timeout, result, cycles : outcome of the last run
module prog_loader_ctl
  import ctl_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] HALT_ADR   = WIDTH'(DEFAULT_HALT_ADR),
  parameter int               CNTW       = 16,
  parameter logic [CNTW-1:0]  MAX_CYCLES = {CNTW{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_valid,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               core_memread,
  input  logic               core_memwrite,
  input  logic [WIDTH-1:0]   core_adr,
  input  logic [WIDTH-1:0]   core_writedata,
  output logic               core_reset,
  output logic               mem_re,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_adr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               done,
  output logic               timeout,
  output logic [WIDTH-1:0]   result,
  output logic [CNTW-1:0]    cycles
);

  localparam logic [CNTW-1:0] LAST_CYCLE = CNTW'(MAX_CYCLES - 1'b1);

  state_t             state_reg;
  logic [WIDTH-1:0]   load_adr_reg;
  logic [CNTW-1:0]    cycles_reg;
  logic               done_reg;
  logic               timeout_reg;
  logic [WIDTH-1:0]   result_reg;
  state_t             port_state;

  // While reset is held the port behaves as in IDLE, so a reset landing in
  // the middle of LOAD or RUN cannot leak a write into memory.
  assign port_state = reset ? IDLE : state_reg;

  assign core_reset = (port_state != RUN);
  assign load_ready = (port_state == LOAD);
  assign done       = done_reg;
  assign timeout    = timeout_reg;
  assign result     = result_reg;
  assign cycles     = cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      load_adr_reg <= '0;
      cycles_reg   <= '0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (start) begin
            state_reg    <= LOAD;
            load_adr_reg <= '0;
            cycles_reg   <= '0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            result_reg   <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            // The top address ends the load, so the counter saturates
            // instead of wrapping back onto the start of the program.
            if (load_adr_reg != '1)
              load_adr_reg <= load_adr_reg + 1'b1;
            if (load_last || (load_adr_reg == '1))
              state_reg <= RUN;
          end
        end
        RUN: begin
          cycles_reg <= cycles_reg + 1'b1;
          // Halt store wins over a coincident budget expiry.
          if (core_memwrite && (core_adr == HALT_ADR)) begin
            result_reg <= core_writedata;
            done_reg   <= 1'b1;
            state_reg  <= HALT;
          end else if (cycles_reg == LAST_CYCLE) begin
            timeout_reg <= 1'b1;
            state_reg   <= HALT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  port_mux #(.WIDTH(WIDTH)) u_port_mux (
    .state          (port_state),
    .load_valid     (load_valid),
    .load_adr       (load_adr_reg),
    .load_data      (load_data),
    .core_memread   (core_memread),
    .core_memwrite  (core_memwrite),
    .core_adr       (core_adr),
    .core_writedata (core_writedata),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .mem_adr        (mem_adr),
    .mem_wdata      (mem_wdata)
  );

endmodule

// File: tb/tb_prog_loader_ctl.sv
// Testbench for prog_loader_ctl: directed table vectors, hand sequences for
// load/run/halt/timeout/reset corners, and randomized load+run transactions
// checked against a memory-image and run-outcome model.
module tb_prog_loader_ctl;

  localparam int MAXC = 40;

  logic        clk = 1'b0;
  logic        reset, start, load_valid, load_last;
  logic [7:0]  load_data;
  logic        core_memread, core_memwrite;
  logic [7:0]  core_adr, core_writedata;
  logic        core_reset, load_ready, mem_re, mem_we, done, timeout;
  logic [7:0]  mem_adr, mem_wdata, result;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];      // memory attached to the DUT port
  logic [7:0] exp_mem [256];  // expected memory image
  logic [7:0] prog [256];     // program to stream
  logic       mem_init;

  prog_loader_ctl #(
    .WIDTH(8), .HALT_ADR(8'hFF), .CNTW(16), .MAX_CYCLES(16'(MAXC))
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .core_memread(core_memread), .core_memwrite(core_memwrite),
    .core_adr(core_adr), .core_writedata(core_writedata),
    .core_reset(core_reset),
    .mem_re(mem_re), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .done(done), .timeout(timeout), .result(result), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_adr] <= mem_wdata;
    end
  end

  typedef struct {
    bit         run;
    logic       rd, wr;
    logic [7:0] adr, wd;
    logic       lv;
    logic [7:0] ld;
    logic       e_re, e_we;
    logic [7:0] e_adr, e_wd;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    core_memread = 1'b0; core_memwrite = 1'b0; core_adr = 8'h00; core_writedata = 8'h00;
  endtask

  task automatic mem_compare(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(name, 32'(bad), 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    to_next();
    to_next();
    reset = 1'b0;
    to_mid();
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_adr", 32'(mem_adr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cycles", 32'(cycles), 0);
    to_next();
  endtask

  // Start pulse, then one idle LOAD cycle confirming the outcome was cleared.
  task automatic pulse_start();
    start = 1'b1;
    to_mid();
    to_next();
    start = 1'b0;
    to_mid();
    chk("start_load_ready", 32'(load_ready), 1);
    chk("start_done_clr", 32'(done), 0);
    chk("start_timeout_clr", 32'(timeout), 0);
    chk("start_result_clr", 32'(result), 0);
    chk("start_cycles_clr", 32'(cycles), 0);
    to_next();
  endtask

  // Stream prog[0..n-1]; returns with the DUT in its first RUN cycle.
  task automatic load_bytes(input int n, input bit use_last, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      int g = gaps ? int'($urandom_range(2)) : 0;
      for (int k = 0; k < g; k++) begin
        load_valid = 1'b0; load_data = 8'($urandom); load_last = 1'($urandom);
        to_mid();
        chk("gap_mem_we", 32'(mem_we), 0);
        chk("gap_load_ready", 32'(load_ready), 1);
        to_next();
      end
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == n - 1);
      start      = (i == start_at);
      to_mid();
      chk("load_mem_we", 32'(mem_we), 1);
      chk("load_mem_adr", 32'(mem_adr), 32'(i));
      chk("load_mem_wdata", 32'(mem_wdata), 32'(prog[i]));
      chk("load_core_reset", 32'(core_reset), 1);
      exp_mem[i] = prog[i];
      to_next();
      start = 1'b0;
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  // Run model: the run lasts until the halt store or MAXC cycles, whichever
  // comes first; a halt store on cycle MAXC still counts as a halt.
  task automatic run_core(input int halt_at, input int start_at);
    bit         halts = (halt_at >= 1) && (halt_at <= MAXC);
    int         limit = halts ? halt_at : MAXC;
    logic [7:0] halt_val = 8'($urandom);
    for (int c = 1; c <= limit; c++) begin
      if (c == halt_at) begin
        core_memread = 1'b0; core_memwrite = 1'b1; core_adr = 8'hFF; core_writedata = halt_val;
      end else begin
        core_memread = 1'($urandom); core_memwrite = 1'($urandom);
        core_adr = 8'($urandom_range(254)); core_writedata = 8'($urandom);
      end
      start = (c == start_at);
      to_mid();
      if (c == 1) chk("run_core_reset", 32'(core_reset), 0);
      chk("run_mem_we", 32'(mem_we), 32'(core_memwrite));
      chk("run_mem_re", 32'(mem_re), 32'(core_memread));
      chk("run_mem_adr", 32'(mem_adr), 32'(core_adr));
      if (core_memwrite) exp_mem[core_adr] = core_writedata;
      to_next();
      start = 1'b0;
    end
    idle_inputs();
    for (int h = 0; h < 2; h++) begin
      core_memwrite = 1'b1; core_adr = 8'h33; core_writedata = 8'hEE;  // ignored in HALT
      to_mid();
      chk("end_done", 32'(done), 32'(halts));
      chk("end_timeout", 32'(timeout), 32'(!halts));
      chk("end_result", 32'(result), halts ? 32'(halt_val) : 0);
      chk("end_cycles", 32'(cycles), 32'(limit));
      chk("end_core_reset", 32'(core_reset), 1);
      chk("end_mem_we", 32'(mem_we), 0);
      to_next();
    end
    idle_inputs();
    $display("run: halt_at=%0d cycles=%0d done=%0b timeout=%0b result=%02h", halt_at, cycles, done, timeout, result);
  endtask

  initial begin
    vecs[0] = '{0, 1, 1, 8'h12, 8'h34, 1, 8'h99, 0, 0, 8'h00, 8'h00};
    vecs[1] = '{0, 0, 1, 8'hFF, 8'h2A, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    vecs[2] = '{0, 1, 0, 8'h80, 8'h01, 1, 8'h55, 0, 0, 8'h00, 8'h00};
    vecs[3] = '{0, 0, 0, 8'hAA, 8'hBB, 1, 8'hCC, 0, 0, 8'h00, 8'h00};
    vecs[4] = '{1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 8'h00};
    vecs[5] = '{1, 0, 1, 8'h40, 8'h55, 0, 8'h00, 0, 1, 8'h40, 8'h55};
    vecs[6] = '{1, 1, 1, 8'hFE, 8'hA5, 0, 8'h00, 1, 1, 8'hFE, 8'hA5};
    vecs[7] = '{1, 0, 0, 8'h12, 8'h34, 0, 8'h00, 0, 0, 8'h12, 8'h34};
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;

    mem_init = 1'b1;
    reset = 1'b1;
    idle_inputs();
    to_next();
    mem_init = 1'b0;
    do_reset();

    // IDLE: nothing reaches memory whatever the inputs do
    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].run) begin
        core_memread = vecs[i].rd; core_memwrite = vecs[i].wr;
        core_adr = vecs[i].adr; core_writedata = vecs[i].wd;
        load_valid = vecs[i].lv; load_data = vecs[i].ld;
        to_mid();
        chk("idle_mem_re", 32'(mem_re), 32'(vecs[i].e_re));
        chk("idle_mem_we", 32'(mem_we), 32'(vecs[i].e_we));
        chk("idle_mem_adr", 32'(mem_adr), 32'(vecs[i].e_adr));
        chk("idle_mem_wdata", 32'(mem_wdata), 32'(vecs[i].e_wd));
        chk("idle_load_ready", 32'(load_ready), 0);
        to_next();
      end
    end
    idle_inputs();

    // Directed: 4-byte program, table vectors in RUN, halt store on cycle 37
    prog[0] = 8'h80; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h00;
    pulse_start();
    load_bytes(4, 1'b1, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].run) begin
        core_memread = vecs[i].rd; core_memwrite = vecs[i].wr;
        core_adr = vecs[i].adr; core_writedata = vecs[i].wd;
        to_mid();
        chk("tv_core_reset", 32'(core_reset), 0);
        chk("tv_mem_re", 32'(mem_re), 32'(vecs[i].e_re));
        chk("tv_mem_we", 32'(mem_we), 32'(vecs[i].e_we));
        chk("tv_mem_adr", 32'(mem_adr), 32'(vecs[i].e_adr));
        chk("tv_mem_wdata", 32'(mem_wdata), 32'(vecs[i].e_wd));
        if (vecs[i].wr) exp_mem[vecs[i].adr] = vecs[i].wd;
        to_next();
      end
    end
    idle_inputs();
    for (int c = 5; c < 37; c++) to_next();
    core_memwrite = 1'b1; core_adr = 8'hFF; core_writedata = 8'h2A;
    to_mid();
    chk("halt_mem_we", 32'(mem_we), 1);
    chk("halt_mem_adr", 32'(mem_adr), 32'hFF);
    exp_mem[8'hFF] = 8'h2A;
    to_next();
    idle_inputs();
    to_mid();
    chk("d1_done", 32'(done), 1);
    chk("d1_result", 32'(result), 32'h2A);
    chk("d1_cycles", 32'(cycles), 37);
    chk("d1_timeout", 32'(timeout), 0);
    chk("d1_core_reset", 32'(core_reset), 1);
    to_next();
    mem_compare("d1_mem");
    $display("directed halt: cycles=%0d result=%02h", cycles, result);

    // Budget expiry, then halt store coincident with expiry
    for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
    pulse_start();
    load_bytes(3, 1'b1, 1'b1, -1);
    run_core(0, -1);
    pulse_start();
    load_bytes(2, 1'b1, 1'b0, -1);
    run_core(MAXC, -1);

    // 256 bytes without load_last, with gaps and an ignored start mid-load;
    // a start during RUN is ignored too
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    pulse_start();
    load_bytes(256, 1'b0, 1'b1, 100);
    run_core(5, 2);
    mem_compare("full_mem");

    // Reset in the middle of RUN, with a write pending in the reset cycle
    prog[0] = 8'h11; prog[1] = 8'h22;
    pulse_start();
    load_bytes(2, 1'b1, 1'b0, -1);
    to_next(); to_next(); to_next();
    core_memwrite = 1'b1; core_adr = 8'h10; core_writedata = 8'h77;
    reset = 1'b1;
    to_mid();
    chk("rstrun_mem_we", 32'(mem_we), 0);
    chk("rstrun_core_reset", 32'(core_reset), 1);
    to_next();
    reset = 1'b0;
    idle_inputs();
    to_mid();
    chk("rstrun_idle_ready", 32'(load_ready), 0);
    chk("rstrun_cycles", 32'(cycles), 0);
    chk("rstrun_done", 32'(done), 0);
    to_next();
    mem_compare("rstrun_mem");
    for (int i = 0; i < 3; i++) prog[i] = 8'($urandom);
    pulse_start();
    load_bytes(3, 1'b1, 1'b0, -1);
    run_core(7, -1);

    // Randomized transactions, each restarted from HALT
    for (int t = 0; t < 8; t++) begin
      int n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
      pulse_start();
      load_bytes(n, 1'b1, 1'b1, int'($urandom_range(n + 5)));
      run_core(int'($urandom_range(MAXC + 3)), int'($urandom_range(MAXC)));
    end
    mem_compare("final_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
